// File: rtl/nabp_shift_sequencer_if.sv
// Handshake bundle between the per-angle sequencer, the host, the tangent ROM and the line-buffer shifter.
interface nabp_shift_sequencer_if #(
    parameter int ANGLE_W = 8,
    parameter int ACCU_W  = 16
);
    logic               kick;
    logic               abort;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [ANGLE_W-1:0] angle;
    logic [ANGLE_W-1:0] rom_addr;
    logic [ACCU_W-1:0]  rom_data;
    logic               pe_ready;
    logic               sh_fill_kick;
    logic               sh_shift_kick;
    logic [ACCU_W-1:0]  sh_accu_base;
    logic               sh_fill_done;
    logic               sh_shift_done;

    modport master (
        input  kick, abort, rom_data, pe_ready, sh_fill_done, sh_shift_done,
        output busy, done, aborted, angle, rom_addr,
               sh_fill_kick, sh_shift_kick, sh_accu_base
    );

    modport slave (
        output kick, abort, rom_data, pe_ready, sh_fill_done, sh_shift_done,
        input  busy, done, aborted, angle, rom_addr,
               sh_fill_kick, sh_shift_kick, sh_accu_base
    );
endinterface

// File: rtl/nabp_shift_sequencer.sv
// Per-angle controller: fetches the tangent-ROM accumulator base, then drives the shifter
// through fill and PE-gated shift for every projection angle of a run.
module nabp_shift_sequencer #(
    parameter int ANGLE_CNT = 180,
    parameter int ANGLE_W   = 8,
    parameter int ACCU_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nabp_shift_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ROM_RD  = 3'd1,
        ROM_LAT = 3'd2,
        FILL    = 3'd3,
        WAIT_PE = 3'd4,
        SHIFT   = 3'd5,
        NEXT    = 3'd6
    } state_t;

    localparam logic [ANGLE_W-1:0] ANGLE_LAST = ANGLE_W'(ANGLE_CNT - 1);
    localparam logic [ANGLE_W-1:0] ANGLE_ONE  = ANGLE_W'(1);
    localparam logic [ANGLE_W-1:0] ANGLE_ZERO = {ANGLE_W{1'b0}};

    state_t              state_q, state_d;
    logic [ANGLE_W-1:0]  angle_q, angle_d;
    logic [ANGLE_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ACCU_W-1:0]   accu_base_q, accu_base_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic                fill_kick_q, fill_kick_d;
    logic                shift_kick_q, shift_kick_d;

    // Next-state and next-output logic; the ROM address is launched together with the
    // transition into ROM_RD so the one-cycle ROM read lands in ROM_LAT.
    always_comb begin
        state_d      = state_q;
        angle_d      = angle_q;
        rom_addr_d   = rom_addr_q;
        accu_base_d  = accu_base_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        fill_kick_d  = 1'b0;
        shift_kick_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.kick && !bus.abort) begin
                    state_d    = ROM_RD;
                    angle_d    = ANGLE_ZERO;
                    rom_addr_d = ANGLE_ZERO;
                    busy_d     = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ROM_RD: begin
                rom_addr_d = angle_q;
                state_d    = ROM_LAT;
            end
            ROM_LAT: begin
                accu_base_d = bus.rom_data;
                fill_kick_d = 1'b1;
                state_d     = FILL;
            end
            FILL: begin
                if (bus.sh_fill_done) begin
                    if (bus.abort) begin
                        state_d   = IDLE;
                        aborted_d = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        state_d = WAIT_PE;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            WAIT_PE: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                    busy_d    = 1'b0;
                end else if (bus.pe_ready) begin
                    shift_kick_d = 1'b1;
                    state_d      = SHIFT;
                end else begin
                    state_d = WAIT_PE;
                end
            end
            SHIFT: begin
                if (bus.sh_shift_done) begin
                    state_d = NEXT;
                end else begin
                    state_d = SHIFT;
                end
            end
            NEXT: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                    busy_d    = 1'b0;
                end else if (angle_q == ANGLE_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    angle_d    = angle_q + ANGLE_ONE;
                    rom_addr_d = angle_q + ANGLE_ONE;
                    state_d    = ROM_RD;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            angle_q      <= ANGLE_ZERO;
            rom_addr_q   <= ANGLE_ZERO;
            accu_base_q  <= {ACCU_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            fill_kick_q  <= 1'b0;
            shift_kick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            angle_q      <= angle_d;
            rom_addr_q   <= rom_addr_d;
            accu_base_q  <= accu_base_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            fill_kick_q  <= fill_kick_d;
            shift_kick_q <= shift_kick_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.aborted       = aborted_q;
    assign bus.angle         = angle_q;
    assign bus.rom_addr      = rom_addr_q;
    assign bus.sh_accu_base  = accu_base_q;
    assign bus.sh_fill_kick  = fill_kick_q;
    assign bus.sh_shift_kick = shift_kick_q;
endmodule
